// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory arbiter and the pipeline around it.
package dmem_pkg;

  localparam int unsigned DMEM_ADDR_W = 8;
  localparam int unsigned DMEM_DATA_W = 8;

  // Wide enough for LOCK_MAX up to 15.
  localparam int unsigned LOCK_CNT_W = 4;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_ADD   = 3'd1,
    OP_SUB   = 3'd2,
    OP_LOAD  = 3'd3,
    OP_STORE = 3'd4
  } opcode_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Core, host and memory-side signals of the data-memory arbiter.
interface dmem_arbiter_if
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = DMEM_ADDR_W,
  parameter int unsigned DATA_W = DMEM_DATA_W
);

  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_gnt;
  logic              core_stall;
  logic              core_rvalid;
  logic [DATA_W-1:0] core_rdata;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_lock;
  logic              host_gnt;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    input  host_req, host_we, host_addr, host_wdata, host_lock,
    input  mem_rdata,
    output core_gnt, core_stall, core_rvalid, core_rdata,
    output host_gnt, host_rvalid, host_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  // Requester / memory side.
  modport master (
    output core_req, core_we, core_addr, core_wdata,
    output host_req, host_we, host_addr, host_wdata, host_lock,
    output mem_rdata,
    input  core_gnt, core_stall, core_rvalid, core_rdata,
    input  host_gnt, host_rvalid, host_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/rr_lock_pointer.sv
// Two-way priority pointer with host burst retention; produces the one-hot grant.
module rr_lock_pointer
  import dmem_pkg::*;
#(
  parameter int unsigned LOCK_MAX = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_core_req,
  input  logic       i_host_req,
  input  logic       i_host_lock,
  output logic [1:0] o_gnt_c
);

  localparam logic [LOCK_CNT_W:0] LOCK_LIMIT = (LOCK_CNT_W + 1)'(LOCK_MAX);

  owner_e                r_ptr;
  owner_e                w_ptr_nxt;
  logic [LOCK_CNT_W-1:0] r_cnt;
  logic [LOCK_CNT_W-1:0] w_cnt_nxt;
  logic [LOCK_CNT_W:0]   w_cnt_inc;

  // Pointer and lock counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= OWN_CORE;
      r_cnt <= '0;
    end else begin
      r_ptr <= w_ptr_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  // Grant selection and pointer/lock next state.
  always_comb begin
    o_gnt_c   = 2'b00;
    w_ptr_nxt = r_ptr;
    w_cnt_nxt = r_cnt;
    w_cnt_inc = {1'b0, r_cnt} + (LOCK_CNT_W + 1)'(1);

    if (i_core_req && (!i_host_req || (r_ptr == OWN_CORE))) begin
      o_gnt_c[0] = 1'b1;
    end else if (i_host_req) begin
      o_gnt_c[1] = 1'b1;
    end

    if (!i_host_lock) begin
      w_cnt_nxt = '0;
    end

    if (o_gnt_c[0]) begin
      w_ptr_nxt = OWN_HOST;
      w_cnt_nxt = '0;
    end else if (o_gnt_c[1]) begin
      if (!i_host_lock) begin
        w_ptr_nxt = OWN_CORE;
      end else if (i_core_req) begin
        // Host keeps priority until it has held the core off LOCK_MAX times.
        if (w_cnt_inc >= LOCK_LIMIT) begin
          w_ptr_nxt = OWN_CORE;
          w_cnt_nxt = '0;
        end else begin
          w_ptr_nxt = OWN_HOST;
          w_cnt_nxt = w_cnt_inc[LOCK_CNT_W-1:0];
        end
      end else begin
        w_ptr_nxt = OWN_HOST;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the core MEM stage and the host port.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W   = DMEM_ADDR_W,
  parameter int unsigned DATA_W   = DMEM_DATA_W,
  parameter int unsigned LOCK_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);

  logic [1:0]        w_gnt;
  logic              w_core_gnt;
  logic              w_host_gnt;
  logic              w_any_gnt;
  owner_e            w_win_owner;
  logic              w_win_we;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_wdata;

  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_rd_pending;
  owner_e            r_rd_owner;
  logic              r_core_rvalid;
  logic [DATA_W-1:0] r_core_rdata;
  logic              r_host_rvalid;
  logic [DATA_W-1:0] r_host_rdata;

  rr_lock_pointer #(
    .LOCK_MAX (LOCK_MAX)
  ) u_ptr (
    .clk         (clk),
    .reset       (reset),
    .i_core_req  (bus.core_req),
    .i_host_req  (bus.host_req),
    .i_host_lock (bus.host_lock),
    .o_gnt_c     (w_gnt)
  );

  assign w_core_gnt = w_gnt[0];
  assign w_host_gnt = w_gnt[1];
  assign w_any_gnt  = w_core_gnt | w_host_gnt;

  // Select the fields of the granted requester.
  always_comb begin
    w_win_owner = OWN_CORE;
    w_win_we    = bus.core_we;
    w_win_addr  = bus.core_addr;
    w_win_wdata = bus.core_wdata;
    if (w_host_gnt) begin
      w_win_owner = OWN_HOST;
      w_win_we    = bus.host_we;
      w_win_addr  = bus.host_addr;
      w_win_wdata = bus.host_wdata;
    end
  end

  // Issue register onto the memory port; tracks which requester owns the read in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_rd_pending <= 1'b0;
      r_rd_owner   <= OWN_CORE;
    end else begin
      r_mem_en     <= w_any_gnt;
      r_mem_we     <= w_any_gnt & w_win_we;
      r_rd_pending <= w_any_gnt & ~w_win_we;
      if (w_any_gnt) begin
        r_mem_addr  <= w_win_addr;
        r_mem_wdata <= w_win_wdata;
      end
      if (w_any_gnt && !w_win_we) begin
        r_rd_owner <= w_win_owner;
      end
    end
  end

  // Read return: capture memory data for the owner and pulse its rvalid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_core_rvalid <= 1'b0;
      r_core_rdata  <= '0;
      r_host_rvalid <= 1'b0;
      r_host_rdata  <= '0;
    end else begin
      r_core_rvalid <= r_rd_pending && (r_rd_owner == OWN_CORE);
      r_host_rvalid <= r_rd_pending && (r_rd_owner == OWN_HOST);
      if (r_rd_pending && (r_rd_owner == OWN_CORE)) begin
        r_core_rdata <= bus.mem_rdata;
      end
      if (r_rd_pending && (r_rd_owner == OWN_HOST)) begin
        r_host_rdata <= bus.mem_rdata;
      end
    end
  end

  assign bus.core_gnt    = w_core_gnt;
  assign bus.host_gnt    = w_host_gnt;
  assign bus.core_stall  = bus.core_req & ~w_core_gnt;
  assign bus.core_rvalid = r_core_rvalid;
  assign bus.core_rdata  = r_core_rdata;
  assign bus.host_rvalid = r_host_rvalid;
  assign bus.host_rdata  = r_host_rdata;
  assign bus.mem_en      = r_mem_en;
  assign bus.mem_we      = r_mem_we;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_wdata   = r_mem_wdata;

endmodule
